// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared state encodings and parameter defaults for bus_arbiter
//
// Contents:
//   arb_state_t            - 2-bit arbiter state (CPU, HANDOFF, DEV, RESTORE)
//   ARB_DEFAULT_MAX_BURST  - default cap on device transactions per grant
//   ARB_DEFAULT_CPU_SLOT   - default minimum CPU-running cycles between grants
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_CPU     = 2'd0,
        ARB_HANDOFF = 2'd1,
        ARB_DEV     = 2'd2,
        ARB_RESTORE = 2'd3
    } arb_state_t;

    localparam int ARB_DEFAULT_MAX_BURST = 16;
    localparam int ARB_DEFAULT_CPU_SLOT  = 4;

endpackage

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - shares the byte-wide memory port between the CPU core and one burst device
//
// Ports:
//   clock, reset            - system clock, synchronous active-high reset
//   pll_locked              - PLL lock, gates cpu_run
//   cpu_run                 - core run-enable (core's locked input)
//   cpu_address/o_data/we   - core memory request; cpu_i_data returns read data
//   dev_req                 - device wants the bus (held while it has transactions)
//   dev_address/o_data/we   - device transaction; dev_gnt accepts it this cycle
//   dev_rvalid, dev_i_data  - read data for the transaction granted last cycle
//   mem_address/o_data/we   - memory macro request; mem_i_data is its 1-cycle read data
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int MAX_BURST = ARB_DEFAULT_MAX_BURST,
    parameter int CPU_SLOT  = ARB_DEFAULT_CPU_SLOT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pll_locked,
    output logic        cpu_run,
    input  logic [31:0] cpu_address,
    input  logic [7:0]  cpu_o_data,
    input  logic        cpu_we,
    output logic [7:0]  cpu_i_data,
    input  logic        dev_req,
    input  logic [31:0] dev_address,
    input  logic [7:0]  dev_o_data,
    input  logic        dev_we,
    output logic        dev_gnt,
    output logic        dev_rvalid,
    output logic [7:0]  dev_i_data,
    output logic [31:0] mem_address,
    output logic [7:0]  mem_o_data,
    output logic        mem_we,
    input  logic [7:0]  mem_i_data
);

    localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);
    localparam logic [7:0] SLOT_LIMIT  = 8'(CPU_SLOT);

    arb_state_t state;
    logic [7:0] slot_cnt;
    logic [7:0] burst_cnt;
    logic [7:0] burst_next;

    assign burst_next = burst_cnt + 8'd1;

    assign cpu_run = (state == ARB_CPU) & pll_locked & ~reset;

    // A reset landing in DEV kills the grant in that same cycle, so an
    // aborted burst never issues a half-finished transaction.
    assign dev_gnt = (state == ARB_DEV) & dev_req & ~reset;

    assign cpu_i_data = mem_i_data;
    assign dev_i_data = mem_i_data;

    // Mux selects depend on the state register only; dev_gnt is the lone
    // same-cycle path from dev_req.
    always_comb begin
        mem_address = cpu_address;
        mem_o_data  = cpu_o_data;
        mem_we      = 1'b0;
        case (state)
            // A core stalled by PLL loss keeps its write on the pins; it
            // must not be repeated every stalled cycle.
            ARB_CPU:     mem_we = cpu_we & cpu_run;
            // The core is frozen but still presents the request it issued
            // on its last running cycle; let a pending write land once here.
            ARB_HANDOFF: mem_we = cpu_we & ~reset;
            ARB_DEV: begin
                mem_address = dev_address;
                mem_o_data  = dev_o_data;
                mem_we      = dev_gnt & dev_we;
            end
            // RESTORE re-reads the frozen fetch address so mem_i_data is
            // already correct on the cycle the core resumes.
            default:     mem_we = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ARB_CPU;
            slot_cnt   <= 8'd0;
            burst_cnt  <= 8'd0;
            dev_rvalid <= 1'b0;
        end else begin
            dev_rvalid <= dev_gnt & ~dev_we;
            case (state)
                ARB_CPU: begin
                    if (cpu_run && slot_cnt != SLOT_LIMIT) begin
                        slot_cnt <= slot_cnt + 8'd1;
                    end
                    if (dev_req && slot_cnt == SLOT_LIMIT) begin
                        state <= ARB_HANDOFF;
                    end
                end
                ARB_HANDOFF: begin
                    burst_cnt <= 8'd0;
                    state     <= ARB_DEV;
                end
                ARB_DEV: begin
                    if (!dev_req) begin
                        state <= ARB_RESTORE;
                    end else begin
                        // The grant that reaches the cap is still performed.
                        burst_cnt <= burst_next;
                        if (burst_next == BURST_LIMIT) begin
                            state <= ARB_RESTORE;
                        end
                    end
                end
                default: begin
                    slot_cnt <= 8'd0;
                    state    <= ARB_CPU;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - scoreboard bench for bus_arbiter with a 1-cycle memory model
module tb_bus_arbiter;

    logic        clock = 1'b0;
    logic        reset, pll_locked, cpu_run;
    logic [31:0] cpu_address, dev_address, mem_address;
    logic [7:0]  cpu_o_data, cpu_i_data, dev_o_data, dev_i_data, mem_o_data, mem_i_data;
    logic        cpu_we, dev_req, dev_we, dev_gnt, dev_rvalid, mem_we;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rd_tbl [0:2] = '{8'hA1, 8'hA2, 8'hA3};

    logic [7:0] mem [0:511];
    int         wr20_cnt = 0;

    always #5 clock = ~clock;

    bus_arbiter #(.MAX_BURST(4), .CPU_SLOT(4)) dut (
        .clock(clock), .reset(reset), .pll_locked(pll_locked), .cpu_run(cpu_run),
        .cpu_address(cpu_address), .cpu_o_data(cpu_o_data), .cpu_we(cpu_we), .cpu_i_data(cpu_i_data),
        .dev_req(dev_req), .dev_address(dev_address), .dev_o_data(dev_o_data), .dev_we(dev_we),
        .dev_gnt(dev_gnt), .dev_rvalid(dev_rvalid), .dev_i_data(dev_i_data),
        .mem_address(mem_address), .mem_o_data(mem_o_data), .mem_we(mem_we), .mem_i_data(mem_i_data)
    );

    initial begin
        for (int i = 0; i < 512; i++) mem[i] <= 8'h00;
        mem[9'h100] <= 8'hA1;
        mem[9'h101] <= 8'hA2;
        mem[9'h102] <= 8'hA3;
        mem[9'h044] <= 8'h5C;
    end

    always @(posedge clock) begin
        if (mem_we) begin
            mem[mem_address[8:0]] <= mem_o_data;
            if (mem_address == 32'h20) wr20_cnt <= wr20_cnt + 1;
        end
        mem_i_data <= mem[mem_address[8:0]];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    // Monitor: every read response is matched against the queue filled at grant time.
    initial begin
        forever begin
            @(negedge clock);
            if (dev_rvalid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rvalid_unexpected: got data %02h want no response", dev_i_data);
                end else begin
                    check("rdata", {56'd0, dev_i_data}, {56'd0, exp_q.pop_front()});
                end
            end
        end
    end

    // Device plus core model for one freeze window. The device holds dev_req
    // until n grants were seen; with core_write the core presents a write to
    // 0x20 from the first frozen cycle (issued on its last running cycle).
    task automatic burst(input int n, input logic we, input logic [31:0] base, input logic core_write,
                         output int low, output int granted, output int first_gnt,
                         output logic rest_we, output logic [31:0] rest_addr,
                         output logic [7:0] resume_data, output logic done);
        logic seen_low;
        seen_low = 1'b0; low = 0; granted = 0; first_gnt = -1; done = 1'b0;
        rest_we = 1'b1; rest_addr = '0; resume_data = '0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (c > 0) tick();
            dev_req     = (granted < n);
            dev_address = base + 32'(granted % 3);
            dev_o_data  = 8'h60 + 8'(granted);
            dev_we      = we;
            if (core_write && !cpu_run && !seen_low) begin
                cpu_address = 32'h20; cpu_o_data = 8'h55; cpu_we = 1'b1;
            end
            if (cpu_run && seen_low) begin
                done = 1'b1; cpu_we = 1'b0; cpu_address = 32'h44;
            end
            sample();
            if (done) resume_data = cpu_i_data;
            else if (!cpu_run) begin
                seen_low = 1'b1; low++; rest_we = mem_we; rest_addr = mem_address;
            end
            if (dev_gnt) begin
                if (first_gnt < 0) first_gnt = c;
                if (!we) exp_q.push_back(rd_tbl[granted % 3]);
                granted++;
            end
        end
    endtask

    int          low, granted, first_gnt, w0, first, lows, gnts, run_ok;
    logic        rest_we, done, dropped;
    logic [31:0] rest_addr;
    logic [7:0]  resume_data;
    logic        run_log [0:39];
    logic        gnt_log [0:39];

    initial begin
        reset = 1'b1; pll_locked = 1'b1;
        cpu_address = 32'h40; cpu_o_data = 8'h99; cpu_we = 1'b1;
        dev_req = 1'b0; dev_address = '0; dev_o_data = '0; dev_we = 1'b0;
        tick(); tick(); sample();
        check("reset_cpu_run", 64'(cpu_run), 64'd0);
        check("reset_dev_gnt", 64'(dev_gnt), 64'd0);
        check("reset_rvalid", 64'(dev_rvalid), 64'd0);
        check("reset_mem_we", 64'(mem_we), 64'd0);
        check("reset_mem_addr", 64'(mem_address), 64'h40);

        // Idle device: memory follows the core every cycle.
        tick(); reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (i > 0) tick();
            cpu_address = 32'h180 + 32'(i % 32);
            cpu_o_data  = 8'(i * 7);
            cpu_we      = (i % 2 == 1);
            sample();
            check("idle", {21'd0, cpu_run, dev_gnt, mem_we, mem_o_data, mem_address},
                  {21'd0, 1'b1, 1'b0, cpu_we, cpu_o_data, cpu_address});
        end
        tick(); cpu_we = 1'b0; pll_locked = 1'b0;
        sample();
        check("pll_unlocked_run", 64'(cpu_run), 64'd0);
        check("pll_unlocked_we", 64'(mem_we), 64'd0);
        tick(); pll_locked = 1'b1;

        // Single read burst after 4 CPU cycles.
        reset = 1'b1; cpu_address = 32'h44;
        tick(); reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            sample();
            check("slot_fill_run", 64'(cpu_run), 64'd1);
        end
        tick();
        burst(3, 1'b0, 32'h100, 1'b0, low, granted, first_gnt, rest_we, rest_addr, resume_data, done);
        check("rd_timeout", 64'(done), 64'd1);
        check("rd_grants", 64'(granted), 64'd3);
        check("rd_req_to_gnt", 64'(first_gnt), 64'd2);
        // HANDOFF + 3 grants + the DEV cycle that sees dev_req low + RESTORE
        check("rd_freeze_len", 64'(low), 64'd6);
        check("rd_restore_we", 64'(rest_we), 64'd0);
        check("rd_restore_addr", 64'(rest_addr), 64'h44);
        check("rd_resume_data", 64'(resume_data), 64'h5C);

        // Pending CPU write across the handoff, device performs two writes.
        w0 = wr20_cnt;
        tick();
        burst(2, 1'b1, 32'h1C0, 1'b1, low, granted, first_gnt, rest_we, rest_addr, resume_data, done);
        check("wr_timeout", 64'(done), 64'd1);
        check("wr_freeze_len", 64'(low), 64'd5);
        check("wr_restore_we", 64'(rest_we), 64'd0);
        check("wr_restore_addr", 64'(rest_addr), 64'h20);
        check("wr_resume_data", 64'(resume_data), 64'h55);
        tick(); sample();
        check("wr_cpu_once", 64'(wr20_cnt - w0), 64'd1);
        check("wr_cpu_data", 64'(mem[9'h020]), 64'h55);
        check("wr_dev0", 64'(mem[9'h1C0]), 64'h60);
        check("wr_dev1", 64'(mem[9'h1C1]), 64'h61);

        // Burst cap with dev_req held high: period of 11 cycles from the first grant.
        gnts = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            dev_req = 1'b1; dev_we = 1'b0; dev_address = 32'h100 + 32'(gnts % 3);
            sample();
            run_log[c] = cpu_run; gnt_log[c] = dev_gnt;
            if (dev_gnt) begin
                exp_q.push_back(rd_tbl[gnts % 3]);
                gnts++;
            end
        end
        first = -1;
        for (int c = 0; c < 40; c++) if (first < 0 && gnt_log[c]) first = c;
        if (first < 0 || first > 17) check("cap_first_gnt", 64'(first), 64'd17);
        else begin
            for (int k = 0; k < 22; k++) begin
                check("cap_pattern", {62'd0, run_log[first + k], gnt_log[first + k]},
                      {62'd0, ((k % 11) >= 5 && (k % 11) <= 9), ((k % 11) <= 3)});
            end
        end
        tick(); dev_req = 1'b0;
        run_ok = 0;
        for (int c = 0; c < 40 && run_ok < 6; c++) begin
            tick(); sample();
            run_ok = cpu_run ? run_ok + 1 : 0;
        end
        check("cap_settle", 64'(run_ok), 64'd6);

        // Zero-length grant: dev_req drops during HANDOFF.
        tick(); dev_req = 1'b1; dropped = 1'b0; lows = 0; gnts = 0;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) tick();
            if (!cpu_run || dropped) begin dev_req = 1'b0; dropped = 1'b1; end
            sample();
            if (!cpu_run) lows++;
            if (dev_gnt) gnts++;
        end
        check("zero_freeze_len", 64'(lows), 64'd3);
        check("zero_grants", 64'(gnts), 64'd0);

        // Reset on the 2nd DEV cycle.
        tick(); dev_req = 1'b1; dev_we = 1'b0; dev_address = 32'h100; done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            if (c > 0) tick();
            sample();
            if (dev_gnt) begin done = 1'b1; exp_q.push_back(rd_tbl[0]); end
        end
        check("rst_first_gnt_timeout", 64'(done), 64'd1);
        tick(); reset = 1'b1; dev_address = 32'h101;
        sample();
        tick();
        sample();
        check("rst_cpu_run", 64'(cpu_run), 64'd0);
        check("rst_dev_gnt", 64'(dev_gnt), 64'd0);
        check("rst_rvalid", 64'(dev_rvalid), 64'd0);
        check("rst_mem_addr", 64'(mem_address), 64'(cpu_address));
        tick(); reset = 1'b0; dev_req = 1'b0;
        sample();
        check("rst_release_run", 64'(cpu_run), 64'd1);

        tick(); tick(); sample();
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
